// File: rtl/multdiv_sequencer_if.sv
// Handshake/data bundle between the execute-stage control and the iterative mult/div unit.
interface multdiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiply (radix-2 Booth) / restoring divide, WIDTH iterations per op.
// Define MULTDIV_DIV0_FAST_EN to complete divide-by-zero in a single cycle.
module multdiv_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic               clock,
    input  logic               reset_n,
    multdiv_sequencer_if.slave md_io
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam int unsigned      RW       = 2 * WIDTH + 1;
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MinVal   = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_mult_q, is_mult_d;
    logic [RW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             neg_q, neg_d;
    logic             div0_q, div0_d;
    logic             dovf_q, dovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic             start;
    logic [WIDTH-1:0] op_a, op_b, mag_a, mag_b;

    assign start = md_io.ctrl_MULT | md_io.ctrl_DIV;
    assign op_a  = md_io.data_operandA;
    assign op_b  = md_io.data_operandB;
    assign mag_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    assign mag_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;

    // Booth step: acc_q = {hi[WIDTH-1:0], multiplier[WIDTH-1:0], q_-1}. The sum is one bit
    // wider than hi so subtracting the most negative multiplicand cannot wrap.
    logic [WIDTH:0] hi_ext, m_ext, booth_sum;
    logic [RW-1:0]  booth_nxt;

    assign hi_ext = {acc_q[RW-1], acc_q[RW-1 -: WIDTH]};
    assign m_ext  = {opd_q[WIDTH-1], opd_q};

    always_comb begin
        booth_sum = hi_ext;
        case (acc_q[1:0])
            2'b01:   booth_sum = hi_ext + m_ext;
            2'b10:   booth_sum = hi_ext - m_ext;
            default: booth_sum = hi_ext;
        endcase
    end

    assign booth_nxt = {booth_sum, acc_q[WIDTH:1]};

    // Restoring step: acc_q = {remainder[WIDTH:0], quotient/dividend[WIDTH-1:0]}.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [RW-1:0]    div_nxt;

    assign div_shift = {acc_q[RW-2:WIDTH], acc_q[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, opd_q};
    assign div_nxt   = div_diff[WIDTH+1] ? {div_shift, acc_q[WIDTH-2:0], 1'b0}
                                         : {div_diff[WIDTH:0], acc_q[WIDTH-2:0], 1'b1};

    logic [RW-1:0]    iter_nxt;
    logic [WIDTH-1:0] prod_lo, prod_hi, quo_fin, div_res;
    logic             mul_exc;

    assign iter_nxt = is_mult_q ? booth_nxt : div_nxt;
    assign prod_lo  = iter_nxt[WIDTH:1];
    assign prod_hi  = iter_nxt[RW-1:WIDTH+1];
    assign mul_exc  = (prod_hi != {WIDTH{prod_lo[WIDTH-1]}});
    assign quo_fin  = iter_nxt[WIDTH-1:0];
    assign div_res  = div0_q ? '0 : (neg_q ? (~quo_fin + 1'b1) : quo_fin);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mult_d = is_mult_q;
        acc_d     = acc_q;
        opd_d     = opd_q;
        neg_d     = neg_q;
        div0_d    = div0_q;
        dovf_d    = dovf_q;
        result_d  = result_q;
        exc_d     = exc_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    is_mult_d = md_io.ctrl_MULT;
                    if (md_io.ctrl_MULT) begin
                        opd_d  = op_a;
                        acc_d  = {{WIDTH{1'b0}}, op_b, 1'b0};
                        neg_d  = 1'b0;
                        div0_d = 1'b0;
                        dovf_d = 1'b0;
                    end else begin
                        opd_d  = mag_b;
                        acc_d  = {{(WIDTH+1){1'b0}}, mag_a};
                        neg_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        div0_d = (op_b == '0);
                        dovf_d = (op_a == MinVal) && (op_b == '1);
`ifdef MULTDIV_DIV0_FAST_EN
                        if (op_b == '0) begin
                            state_d  = StDone;
                            result_d = '0;
                            exc_d    = 1'b1;
                        end
`endif
                    end
                end
            end
            StRun: begin
                acc_d = iter_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d  = StDone;
                    result_d = is_mult_q ? prod_lo : div_res;
                    exc_d    = is_mult_q ? mul_exc : (div0_q | dovf_q);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_mult_q <= 1'b0;
            acc_q     <= '0;
            opd_q     <= '0;
            neg_q     <= 1'b0;
            div0_q    <= 1'b0;
            dovf_q    <= 1'b0;
            result_q  <= '0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_mult_q <= is_mult_d;
            acc_q     <= acc_d;
            opd_q     <= opd_d;
            neg_q     <= neg_d;
            div0_q    <= div0_d;
            dovf_q    <= dovf_d;
            result_q  <= result_d;
            exc_q     <= exc_d;
        end
    end

    assign md_io.data_result    = result_q;
    assign md_io.data_exception = exc_q;
    assign md_io.data_resultRDY = (state_q == StDone);
    assign md_io.busy           = (state_q == StRun) | start;

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Iterative signed 32-bit multiply/divide unit in the execute stage. Consumes the one-cycle mult/div start pulses and bypassed operands produced by the pipeline control decode. Runs a WIDTH-cycle shift-add multiply or restoring divide. Provides a result-ready strobe and a stall signal that holds FD/DX while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width in bits; also the iteration count.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  single clock; all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
ctrl_MULT  input  1  start-multiply pulse (DX mult op, opcode 00000)
ctrl_DIV  input  1  start-divide pulse (DX div op, opcode 00000)
data_operandA  input  WIDTH  bypassed ALU A operand; sampled on the start edge only
data_operandB  input  WIDTH  bypassed ALU B operand; sampled on the start edge only
data_result  output  WIDTH  product low word or quotient; valid while data_resultRDY=1
data_exception  output  1  overflow or divide-by-zero; valid while data_resultRDY=1
data_resultRDY  output  1  one-cycle completion strobe
busy  output  1  pipeline stall request

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, counter=0, all internal registers 0, data_result=0, data_exception=0, data_resultRDY=0.
- States:
  - IDLE -> RUN on an edge with (ctrl_MULT|ctrl_DIV)=1.
  - RUN -> DONE on the edge that completes iteration WIDTH-1.
  - DONE -> RUN if a start is present on that edge, else DONE -> IDLE.
- Start edge actions: latch operands, latch op type, clear counter.
  - ctrl_MULT and ctrl_DIV both 1: multiply wins.
  - Start pulses while in RUN are ignored; no queuing.
- Latency: start on edge e0, one iteration per edge e1..eWIDTH, data_resultRDY=1 for exactly the cycle between eWIDTH and eWIDTH+1. Back-to-back issue from DONE therefore gives throughput of WIDTH+1 cycles per op.
- busy (combinational): (state==RUN) | (state!=RUN & (ctrl_MULT|ctrl_DIV)). The stall therefore begins in the issue cycle; busy=0 in DONE unless a new start is present.
- data_result and data_exception are registered and update only on entry to DONE. They are held otherwise; only data_resultRDY marks validity.
- Multiply:
  - Radix-2 Booth on a 2*WIDTH+1 product register.
  - data_result = low WIDTH bits of the signed product.
  - data_exception=1 iff the high WIDTH bits are not all copies of result bit WIDTH-1.
- Divide:
  - Restoring division on magnitudes; quotient sign = signA^signB; truncation toward zero; remainder not exported.
  - B==0: data_result=0, data_exception=1, full WIDTH latency (uniform timing).
  - A==-2^(WIDTH-1), B==-1: data_result=0x80000000, data_exception=1.
- Reset asserted mid-operation: immediate return to IDLE, busy drops combinationally, no data_resultRDY is ever produced for the aborted op.
- Operand inputs changing during RUN have no effect.

Optional Feature:
Macro: MULTDIV_DIV0_FAST_EN.
- Defined: a divide with B==0 goes IDLE/DONE -> DONE directly. data_resultRDY is asserted in the cycle after the start edge, with data_result=0 and data_exception=1; busy is high only in the issue cycle.
- Undefined: divide-by-zero takes the full WIDTH-cycle latency, as specified above.

Test Plan:
- Reset with reset_n=0 mid-RUN of mult 7*6 -> busy=0 immediately; no resultRDY ever produced; outputs 0.
- ctrl_MULT pulse, A=7, B=-6 -> busy=1 for 33 cycles (issue + 32 RUN); resultRDY after 32 edges; result=0xFFFFFFD6; exception=0.
- ctrl_MULT, A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. Second case: A=0x7FFFFFFF, B=2 -> result=0xFFFFFFFE, exception=1.
- ctrl_DIV, A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0. Second case: A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- ctrl_DIV, A=5, B=0 -> result=0, exception=1; latency 32 without the macro, 1 with MULTDIV_DIV0_FAST_EN.
- ctrl_MULT and ctrl_DIV both high, A=3, B=4 -> result=12. Extra start pulse mid-RUN is ignored. Start in the DONE cycle -> new op runs with resultRDY 33 cycles after the first strobe.
